// File: rtl/uart_cmd_assembler.sv
// Framed command assembler behind the UART receiver: SYNC, CMD, payload, XOR check.
// Accepted packets are held under valid/ready until the cipher core takes them.
module uart_cmd_assembler #(
   parameter int          CLK_FREQ      = 30_000_000,
   parameter int          BAUD          = 9600,
   parameter int          PAYLOAD_BYTES = 8,
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
   parameter int          TIMEOUT_BYTES = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 rx_data,
   input  logic                       rx_done,
   input  logic                       rx_valid,
   output logic [7:0]                 cmd_out,
   output logic [8*PAYLOAD_BYTES-1:0] payload_out,
   output logic                       pkt_valid,
   input  logic                       pkt_ready,
   output logic                       busy,
   output logic                       err_checksum,
   output logic                       err_frame,
   output logic                       err_timeout,
   output logic                       err_overrun
);

   localparam int TMO_LIM = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD);
   localparam int TW      = $clog2(TMO_LIM) + 1;
   localparam int IW      = $clog2(PAYLOAD_BYTES) + 1;
   localparam int PW      = 8 * PAYLOAD_BYTES;
   // Decided two counts early so the registered pulse lands TMO_LIM clocks after the strobe
   localparam logic [TW-1:0] TMO_HIT  = TW'(TMO_LIM - 2);
   localparam logic [IW-1:0] IDX_LAST = IW'(PAYLOAD_BYTES - 1);

   typedef enum logic [2:0] {S_HUNT, S_CMD, S_PAY, S_CHK, S_HOLD} state_t;

   state_t          state_q, state_d;
   logic            stb_q;
   logic [7:0]      cmd_q, cmd_d;
   logic [7:0]      cout_q, cout_d;
   logic [7:0]      chk_q, chk_d;
   logic [PW-1:0]   sh_q, sh_d;
   logic [PW-1:0]   pout_q, pout_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            ecs_q, ecs_d;
   logic            efr_q, efr_d;
   logic            eto_q, eto_d;
   logic            eov_q, eov_d;
   logic            good, bad, expire, in_pkt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_HUNT;
         stb_q   <= 1'b0;
         cmd_q   <= '0;
         cout_q  <= '0;
         chk_q   <= '0;
         sh_q    <= '0;
         pout_q  <= '0;
         idx_q   <= '0;
         tmo_q   <= '0;
         ecs_q   <= 1'b0;
         efr_q   <= 1'b0;
         eto_q   <= 1'b0;
         eov_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         stb_q   <= rx_done;
         cmd_q   <= cmd_d;
         cout_q  <= cout_d;
         chk_q   <= chk_d;
         sh_q    <= sh_d;
         pout_q  <= pout_d;
         idx_q   <= idx_d;
         tmo_q   <= tmo_d;
         ecs_q   <= ecs_d;
         efr_q   <= efr_d;
         eto_q   <= eto_d;
         eov_q   <= eov_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      cout_d  = cout_q;
      chk_d   = chk_q;
      sh_d    = sh_q;
      pout_d  = pout_q;
      idx_d   = idx_q;
      tmo_d   = '0;
      ecs_d   = 1'b0;
      efr_d   = 1'b0;
      eto_d   = 1'b0;
      eov_d   = 1'b0;
      good    = stb_q & rx_valid;
      bad     = stb_q & ~rx_valid;
      in_pkt  = (state_q == S_CMD) || (state_q == S_PAY) || (state_q == S_CHK);
      expire  = ~stb_q & (tmo_q == TMO_HIT);
      if (in_pkt && !stb_q) tmo_d = tmo_q + TW'(1);
      unique case (state_q)
         S_HUNT: begin
            if (good && rx_data == SYNC_BYTE) begin
               state_d = S_CMD;
               chk_d   = '0;
               idx_d   = '0;
            end
         end
         S_CMD: begin
            if (good) begin
               cmd_d   = rx_data;
               chk_d   = rx_data;
               state_d = S_PAY;
            end
         end
         S_PAY: begin
            if (good) begin
               sh_d  = PW'({sh_q, rx_data});
               chk_d = chk_q ^ rx_data;
               idx_d = idx_q + IW'(1);
               if (idx_q == IDX_LAST) state_d = S_CHK;
            end
         end
         S_CHK: begin
            if (good) begin
               if (rx_data == chk_q) begin
                  state_d = S_HOLD;
                  cout_d  = cmd_q;
                  pout_d  = sh_q;
               end else begin
                  ecs_d   = 1'b1;
                  state_d = S_HUNT;
               end
            end
         end
         S_HOLD: begin
            if (pkt_ready) state_d = S_HUNT;
            if (stb_q) eov_d = 1'b1;
         end
         default: state_d = S_HUNT;
      endcase
      if (in_pkt) begin
         if (bad) begin
            efr_d   = 1'b1;
            state_d = S_HUNT;
         end else if (expire) begin
            eto_d   = 1'b1;
            state_d = S_HUNT;
         end
      end
   end

   assign cmd_out      = cout_q;
   assign payload_out  = pout_q;
   assign pkt_valid    = (state_q == S_HOLD);
   assign busy         = (state_q != S_HUNT);
   assign err_checksum = ecs_q;
   assign err_frame    = efr_q;
   assign err_timeout  = eto_q;
   assign err_overrun  = eov_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler: good/bad packets, backpressure,
// framing, timeout edges and async reset, with hand-computed expectations.
module tb_uart_cmd_assembler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_done = 1'b0;
   logic        rx_valid = 1'b0;
   logic        pkt_ready = 1'b0;
   logic [7:0]  cmd_out;
   logic [31:0] payload_out;
   logic        pkt_valid, busy;
   logic        err_checksum, err_frame, err_timeout, err_overrun;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_chk = 0, n_frm = 0, n_tmo = 0, n_ovr = 0, n_val = 0;
   int b_chk, b_frm, b_tmo, b_ovr, b_val;
   int tmo_cyc = -1;
   int k;

   uart_cmd_assembler #(
      .CLK_FREQ(1000), .BAUD(100), .PAYLOAD_BYTES(4),
      .SYNC_BYTE(8'hA5), .TIMEOUT_BYTES(4)
   ) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
      .rx_valid(rx_valid), .cmd_out(cmd_out), .payload_out(payload_out),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .busy(busy),
      .err_checksum(err_checksum), .err_frame(err_frame),
      .err_timeout(err_timeout), .err_overrun(err_overrun)
   );

   always #5 clk = ~clk;

   // Samples the cycle that ends at this edge; cyc then names the next cycle
   always @(posedge clk) begin
      if (err_checksum) n_chk++;
      if (err_frame) n_frm++;
      if (err_overrun) n_ovr++;
      if (pkt_valid) n_val++;
      if (err_timeout) begin
         n_tmo++;
         tmo_cyc = cyc;
      end
      cyc++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic snap();
      b_chk = n_chk; b_frm = n_frm; b_tmo = n_tmo; b_ovr = n_ovr; b_val = n_val;
   endtask

   task automatic put(input logic [7:0] b, input logic v);
      rx_data  = b;
      rx_valid = v;
      rx_done  = 1'b1;
      @(negedge clk);
      rx_done  = 1'b0;
   endtask

   task automatic putg(input logic [7:0] b, input logic v);
      put(b, v);
      @(negedge clk);
   endtask

   task automatic send_pkt(input logic [7:0] c, input logic [31:0] p, input logic [7:0] ck);
      putg(8'hA5, 1'b1);
      putg(c, 1'b1);
      for (int i = 3; i >= 0; i--) putg(p[i*8 +: 8], 1'b1);
      put(ck, 1'b1);
   endtask

   task automatic check_pkt(input string tag, input logic [7:0] c, input logic [31:0] p);
      check({tag, "_v_early"}, 32'(pkt_valid), 32'd0);
      @(negedge clk);
      check({tag, "_v"}, 32'(pkt_valid), 32'd1);
      check({tag, "_cmd"}, 32'(cmd_out), 32'(c));
      check({tag, "_pay"}, payload_out, p);
      @(negedge clk);
      check({tag, "_v_drop"}, 32'(pkt_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_out", {pkt_valid, busy, err_checksum, err_frame, err_timeout, err_overrun},
            32'd0);
      check("rst_data", {cmd_out, payload_out[23:0]} | 32'(payload_out[31:24]), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      pkt_ready = 1'b1;
      snap();
      send_pkt(8'h01, 32'h11223344, 8'h45);
      check_pkt("good", 8'h01, 32'h11223344);
      check("good_noerr", n_chk + n_frm + n_tmo + n_ovr - b_chk - b_frm - b_tmo - b_ovr, 0);

      pkt_ready = 1'b0;
      snap();
      send_pkt(8'h01, 32'h11223344, 8'h45);
      @(negedge clk);
      check("bp_v", 32'(pkt_valid), 32'd1);
      repeat (50) @(negedge clk);
      putg(8'h55, 1'b1);
      repeat (440) @(negedge clk);
      check("bp_hold", 32'(pkt_valid), 32'd1);
      check("bp_cmd", 32'(cmd_out), 32'h01);
      check("bp_pay", payload_out, 32'h11223344);
      check("bp_ovr", n_ovr - b_ovr, 1);
      check("bp_tmo", n_tmo - b_tmo, 0);
      pkt_ready = 1'b1;
      @(negedge clk);
      check("bp_rel_v", 32'(pkt_valid), 32'd0);
      check("bp_rel_busy", 32'(busy), 32'd0);

      snap();
      putg(8'hA5, 1'b1); putg(8'h01, 1'b1); putg(8'h11, 1'b1);
      putg(8'h22, 1'b1); putg(8'h33, 1'b1); putg(8'h44, 1'b1);
      putg(8'h46, 1'b1);
      @(negedge clk);
      check("cs_err", n_chk - b_chk, 1);
      check("cs_noval", n_val - b_val, 0);
      check("cs_busy", 32'(busy), 32'd0);
      send_pkt(8'h7E, 32'h00FF8001, 8'h00);
      check_pkt("cs_next", 8'h7E, 32'h00FF8001);

      snap();
      putg(8'h00, 1'b0);
      check("hunt_bad", n_frm - b_frm, 0);
      check("hunt_busy", 32'(busy), 32'd0);
      putg(8'hA5, 1'b1); putg(8'h01, 1'b1); putg(8'h11, 1'b1);
      putg(8'h22, 1'b1); putg(8'h33, 1'b0);
      @(negedge clk);
      check("frm_err", n_frm - b_frm, 1);
      check("frm_busy", 32'(busy), 32'd0);

      snap();
      putg(8'hA5, 1'b1); putg(8'h01, 1'b1);
      put(8'h11, 1'b1);
      k = cyc;
      repeat (420) @(negedge clk);
      check("tmo_cnt", n_tmo - b_tmo, 1);
      check("tmo_when", tmo_cyc, k + 400);
      check("tmo_busy", 32'(busy), 32'd0);

      snap();
      putg(8'hA5, 1'b1); putg(8'h01, 1'b1);
      put(8'h11, 1'b1);
      k = cyc;
      while (cyc < k + 398) @(negedge clk);
      putg(8'h22, 1'b1); putg(8'h33, 1'b1); putg(8'h44, 1'b1);
      put(8'h45, 1'b1);
      check_pkt("tmo_edge", 8'h01, 32'h11223344);
      check("tmo_edge_cnt", n_tmo - b_tmo, 0);

      putg(8'hA5, 1'b1); putg(8'h01, 1'b1); putg(8'h11, 1'b1);
      rst = 1'b1;
      #1;
      check("rst_mid_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      pkt_ready = 1'b0;
      send_pkt(8'h01, 32'h11223344, 8'h45);
      @(negedge clk);
      check("rst_hold_v", 32'(pkt_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_hold_out", {cmd_out, 23'd0, pkt_valid}, 32'd0);
      check("rst_hold_pay", payload_out, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pkt_ready = 1'b1;
      @(negedge clk);
      send_pkt(8'hC3, 32'hA5102030, 8'h66);
      check_pkt("rst_after", 8'hC3, 32'hA5102030);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_cmd_assembler.md
Name: uart_cmd_assembler

Overview:
Sits directly downstream of the UART receiver and consumes its byte stream (rx_data, done, valid).
Assembles framed command packets into a parallel command plus payload block for the cipher core:
- Packet format: SYNC, CMD, PAYLOAD_BYTES bytes, CHK.
- Packets are checked for framing, checksum and timeout errors.
- Accepted packets are held under a valid/ready handshake until the core takes them.

Parameters:
CLK_FREQ, 30_000_000, clock frequency in Hz (same value as the receiver)
BAUD, 9600, UART baud rate in Hz
PAYLOAD_BYTES, 8, payload bytes per packet; legal range 1..32
SYNC_BYTE, 8'hA5, packet start marker
TIMEOUT_BYTES, 4, maximum gap between bytes inside a packet, in 10-bit character times

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
rx_data  input  8  byte from receiver
rx_done  input  1  one-cycle pulse, byte received
rx_valid  input  1  high = byte has no framing error
cmd_out  output  8  command byte of held packet
payload_out  output  8*PAYLOAD_BYTES  payload; first received byte in MSBs
pkt_valid  output  1  packet held and stable
pkt_ready  input  1  core accepts held packet
busy  output  1  state other than HUNT
err_checksum  output  1  one-cycle pulse, checksum mismatch
err_frame  output  1  one-cycle pulse, framing-bad byte inside packet
err_timeout  output  1  one-cycle pulse, inter-byte gap exceeded
err_overrun  output  1  one-cycle pulse, byte dropped while in HOLD

Behaviour:
- Reset (async, rst=1): state=HUNT; all outputs 0, including cmd_out, payload_out and the internal checksum/counters.
- Byte capture:
  - rx_done is registered to produce byte_stb.
  - rx_data and rx_valid are sampled on the cycle after rx_done, because the receiver updates its data/valid registers one clock after done.
  - All state decisions below act on byte_stb.
- States:
  - HUNT: byte_stb with rx_valid=1 and byte==SYNC_BYTE -> CMD; clear checksum and payload index. Any other byte, or a framing-bad byte, is ignored with no error pulse.
  - CMD: good byte -> latch cmd register, chk=byte, -> PAYLOAD.
  - PAYLOAD: good byte -> shift into payload (left shift, new byte in LSBs, so the first byte ends in MSBs); chk^=byte; index+1. After byte PAYLOAD_BYTES-1 (0-based) -> CHECK.
  - CHECK: good byte == chk -> HOLD. Mismatch -> err_checksum pulse, -> HUNT.
  - HOLD:
    - pkt_valid=1; cmd_out and payload_out stable.
    - pkt_valid&&pkt_ready -> pkt_valid=0 next cycle, -> HUNT.
    - byte_stb during HOLD -> byte dropped, err_overrun pulse, state unchanged.
- Framing errors: byte_stb with rx_valid=0 in CMD/PAYLOAD/CHECK -> err_frame pulse, -> HUNT. A SYNC_BYTE value inside CMD/PAYLOAD/CHECK is plain data; there is no resync.
- Timeout:
  - Limit = TIMEOUT_BYTES*10*(CLK_FREQ/BAUD) clocks; counter width $clog2(limit)+1.
  - Counter runs in CMD/PAYLOAD/CHECK and clears on every byte_stb and on entering CMD.
  - Reaching the limit -> err_timeout pulse, -> HUNT.
  - If byte_stb and expiry occur in the same cycle, the byte wins and the counter clears.
  - The counter is held at 0 in HUNT and HOLD.
- Output timing:
  - pkt_valid rises exactly 1 cycle after the CHK byte_stb, i.e. 2 cycles after the CHK rx_done.
  - cmd_out and payload_out update only on entry to HOLD; they keep the last accepted packet otherwise.
- Error pulses: exactly one clock wide, at most one per byte_stb, registered outputs.
- busy=1 in every state except HUNT.
- pkt_ready while not in HOLD is ignored.
- rst asserted mid-packet or in HOLD: immediate return to reset values; the partial packet is discarded.

Test Plan:
(Bench parameters: CLK_FREQ=1000, BAUD=100, PAYLOAD_BYTES=4, TIMEOUT_BYTES=4, so timeout = 400 clocks.)
1. Good packet: bytes A5 01 11 22 33 44 45, pkt_ready=1 -> pkt_valid for 1 cycle, 2 clocks after last rx_done; cmd_out=01, payload_out=11223344; no error pulses.
2. Backpressure and overrun: same packet, pkt_ready=0 for 500 clocks while byte 0x55 arrives -> pkt_valid held and outputs stable; err_overrun single pulse; release pkt_ready -> HUNT, busy=0.
3. Checksum failure: A5 01 11 22 33 44 46 -> err_checksum one pulse; pkt_valid stays 0; next good packet is accepted normally.
4. Framing error: rx_valid=0 on third payload byte -> err_frame pulse, busy drops. A leading 0x00 (rx_valid=0) while in HUNT -> no pulse.
5. Timeout: A5 01 11, then silence -> err_timeout exactly 400 clocks after the 0x11 byte_stb. A byte arriving on the expiry cycle -> no pulse; packet continues.
6. Async reset: assert rst for one clock mid-payload and again in HOLD -> all outputs 0 immediately; following good packet decodes correctly.
